wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the processor pipeline, sitting directly upstream of the register file's single write port. Merges results from the main pipeline with results from a long-latency unit (mul/div, loads) into one registered write per cycle. Buffers long-latency results in a small FIFO, kills stale buffered results that a newer pipeline write overtakes, and optionally forwards the in-flight write to the register-file read ports.

## Interface
- DATA_W, 32, register data width
- ADDR_W, 5, register index width
- LL_DEPTH, 2, long-latency FIFO entries; power of two, ≥2
- STARVE_LIM, 8, cycles a FIFO head may be blocked before `ll_starve` asserts
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- pipe_valid  in  1  main-pipeline result valid this cycle
- pipe_rd  in  ADDR_W  destination register of pipeline result
- pipe_data  in  DATA_W  pipeline result
- ll_valid  in  1  long-latency result offered
- ll_ready  out  1  FIFO can accept; transfer when `ll_valid && ll_ready`
- ll_rd  in  ADDR_W  long-latency destination register
- ll_data  in  DATA_W  long-latency result
- ll_starve  out  1  request to upstream to insert one pipeline bubble
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  ADDR_W  register-file write index (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- rd_a_addr, rd_b_addr  in  ADDR_W  register-file read indices
- rf_a_data, rf_b_data  in  DATA_W  raw register-file read data
- fwd_a_data, fwd_b_data  out  DATA_W  read data after optional forwarding (combinational)

## Operation
- Write selection each cycle, priority order:
  1. `pipe_valid && pipe_rd != 0`: pipeline write.
  2. FIFO non-empty: pop the head; write only if the head entry is live.
  3. Otherwise no write.
- `pipe_valid` with `pipe_rd == 0` counts as idle: no write, and the FIFO may pop that cycle.
- FIFO entry: {live, rd, data}.
  - Push on an accepted `ll` transfer. An accepted transfer with `ll_rd == 0` is consumed and not stored.
  - `ll_ready = rst_n && (count < LL_DEPTH)`. Readiness does not depend on a same-cycle pop.
  - No FIFO bypass: an entry pushed at edge N is poppable at the earliest in the cycle after edge N.
- Kill rule: a pipeline write to register R clears `live` on every FIFO entry with rd == R.
  - An `ll` transfer accepted in the same cycle as a pipeline write to the same R is older; it is consumed and not stored.
  - A dead head is popped in its own cycle with `rf_we = 0`.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and a pipeline write wins.
  - Clears on any pop and when the FIFO is empty.
  - `ll_starve = (counter >= STARVE_LIM)`, registered.
- Count width is log2(LL_DEPTH)+1. Head and tail pointers wrap modulo LL_DEPTH.

## Timing
- Reset (asynchronous, while `rst_n` low):
  - `rf_we = 0`, `rf_rd = 0`, `rf_wdata = 0`.
  - FIFO empty with all entries dead; starvation counter 0; `ll_starve = 0`; `ll_ready = 0`.
- First cycle after `rst_n` rises: `ll_ready = 1`.
- Reset mid-operation discards all buffered entries with no write.
- Pipeline latency: result presented in the cycle ending at edge N → `rf_we/rf_rd/rf_wdata` valid during cycle N..N+1 → register file updated at edge N+1.
- Long-latency minimum latency: accepted at edge N → popped in the cycle ending at edge N+1 → `rf_we` during N+1..N+2.
- `ll_starve`: first high in the cycle after the counter reaches STARVE_LIM; low the cycle after the blocking pop.
- Full FIFO: `ll_ready = 0`; no push that cycle even if a pop occurs.
- Simultaneous push and pop when not full: both occur, count unchanged.

## Configuration
- `WB_BYPASS_EN` defined:
  - `fwd_a_data = rf_wdata` when `rf_we && rf_rd == rd_a_addr && rd_a_addr != 0`; else `rf_a_data`.
  - Same rule for port B.
  - Closes the one-cycle window where the register file still returns the old value.
- Not defined: `fwd_a_data = rf_a_data` and `fwd_b_data = rf_b_data`; no comparators are built.

## Test plan
- Pipe only: pipe_valid=1, rd=5, data=0x1234 for one cycle → next cycle `rf_we=1`, `rf_rd=5`, `rf_wdata=0x1234`. Repeat with rd=0 → `rf_we=0`.
- LL idle path: accept rd=7, data=0xAA with pipe idle → `rf_we=1`, `rf_rd=7` two cycles after acceptance. Accepting a third entry with LL_DEPTH=2 and pipe busy → `ll_ready=0`.
- Kill rule: FIFO holds rd=3/0x11; pipe writes rd=3/0x22; then pipe idle → `rf_wdata=0x22` once, then a `rf_we=0` pop cycle. The 0x11 value is never written.
- Starvation: FIFO holds one entry; pipe writes distinct rd≠0 every cycle → `ll_starve=1` after 8 blocked cycles. Drop pipe_valid → entry written, `ll_starve=0` next cycle.
- Bypass (macro on): `rf_we=1`, rf_rd=9, rf_wdata=0x55, rd_a_addr=9, rf_a_data=0x0 → `fwd_a_data=0x55`. Macro off → `0x0`. rd_a_addr=0 → never forwarded.
- Reset mid-operation: FIFO full, pulse rst_n low → `rf_we=0`, `ll_ready=0` immediately. After release, no write occurs from the old entries.

Source files
------------

// File: rtl/wb_stage.sv
// wb_stage: writeback merge of main-pipeline and long-latency results into one registered RF write.
// Latency: pipeline result 1 cycle to rf_we; long-latency result at least 2 cycles (buffered, no bypass).
// Backpressure: ll_ready drops when the FIFO is full; ll_starve asks upstream for a pipeline bubble.
//
// Ports: clk/rst_n (async active-low); pipe_* main-pipeline result; ll_* long-latency handshake;
//        rf_we/rf_rd/rf_wdata registered RF write; rd_*_addr/rf_*_data raw RF reads; fwd_*_data read results.
// Optional feature: define WB_BYPASS_EN to forward the in-flight write onto the read ports.
module wb_stage #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int LL_DEPTH   = 2,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_valid,
    input  logic [ADDR_W-1:0] pipe_rd,
    input  logic [DATA_W-1:0] pipe_data,
    input  logic              ll_valid,
    output logic              ll_ready,
    input  logic [ADDR_W-1:0] ll_rd,
    input  logic [DATA_W-1:0] ll_data,
    output logic              ll_starve,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] rd_a_addr,
    input  logic [ADDR_W-1:0] rd_b_addr,
    input  logic [DATA_W-1:0] rf_a_data,
    input  logic [DATA_W-1:0] rf_b_data,
    output logic [DATA_W-1:0] fwd_a_data,
    output logic [DATA_W-1:0] fwd_b_data
);
    localparam int PTR_W = (LL_DEPTH > 1) ? $clog2(LL_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(LL_DEPTH);
    localparam logic [STV_W-1:0] LIM_C   = STV_W'(STARVE_LIM);

    logic [LL_DEPTH-1:0] entLive;
    logic [ADDR_W-1:0]   entRd   [LL_DEPTH];
    logic [DATA_W-1:0]   entData [LL_DEPTH];
    logic [PTR_W-1:0]    headPtr, tailPtr;
    logic [CNT_W-1:0]    count;
    logic [STV_W-1:0]    starveCnt, starveNext;

    logic pipeWr, fifoEmpty, llAccept, doPush, doPop;

    // rd==0 is never written, so such a pipeline result leaves the port to the FIFO.
    assign pipeWr    = pipe_valid && (pipe_rd != '0);
    assign fifoEmpty = (count == '0);
    assign doPop     = !pipeWr && !fifoEmpty;

    assign ll_ready  = rst_n && (count < DEPTH_C);
    assign llAccept  = ll_valid && ll_ready;
    // A same-cycle pipeline write to the same register is newer, so the ll result is dropped.
    assign doPush    = llAccept && (ll_rd != '0) && !(pipeWr && (pipe_rd == ll_rd));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entLive <= '0;
            for (int i = 0; i < LL_DEPTH; i++) begin
                entRd[i]   <= '0;
                entData[i] <= '0;
            end
        end else begin
            // Kill every buffered result the pipeline write overtakes.
            for (int i = 0; i < LL_DEPTH; i++) begin
                if (pipeWr && (entRd[i] == pipe_rd)) begin
                    entLive[i] <= 1'b0;
                end
            end
            if (doPop) begin
                entLive[headPtr] <= 1'b0;
            end
            // Push cannot target the head slot while a pop is live (not full, not empty).
            if (doPush) begin
                entLive[tailPtr] <= 1'b1;
                entRd[tailPtr]   <= ll_rd;
                entData[tailPtr] <= ll_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (doPop) begin
                headPtr <= headPtr + PTR_W'(1);
            end
            if (doPush) begin
                tailPtr <= tailPtr + PTR_W'(1);
            end
            if (doPush && !doPop) begin
                count <= count + CNT_W'(1);
            end else if (doPop && !doPush) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Non-empty without a pop can only mean the pipeline won the port; saturate at the limit.
    always_comb begin
        starveNext = starveCnt;
        if (fifoEmpty || doPop) begin
            starveNext = '0;
        end else if (starveCnt < LIM_C) begin
            starveNext = starveCnt + STV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starveCnt <= '0;
            ll_starve <= 1'b0;
        end else begin
            starveCnt <= starveNext;
            ll_starve <= (starveNext >= LIM_C);
        end
    end

    // rf_rd/rf_wdata hold their last value while rf_we is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
        end else if (pipeWr) begin
            rf_we    <= 1'b1;
            rf_rd    <= pipe_rd;
            rf_wdata <= pipe_data;
        end else if (doPop && entLive[headPtr]) begin
            rf_we    <= 1'b1;
            rf_rd    <= entRd[headPtr];
            rf_wdata <= entData[headPtr];
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_BYPASS_EN
    // Covers the cycle where the RF array has not yet absorbed the registered write.
    assign fwd_a_data = (rf_we && (rf_rd == rd_a_addr) && (rd_a_addr != '0)) ? rf_wdata : rf_a_data;
    assign fwd_b_data = (rf_we && (rf_rd == rd_b_addr) && (rd_b_addr != '0)) ? rf_wdata : rf_b_data;
`else
    // Read indices only matter when forwarding is built.
    logic unusedRdAddr;
    assign unusedRdAddr = ^{rd_a_addr, rd_b_addr};
    assign fwd_a_data   = rf_a_data;
    assign fwd_b_data   = rf_b_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    localparam int DEPTH = 2;
    localparam int LIM   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        ll_valid = 1'b0;
    logic        ll_ready;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_data = '0;
    logic        ll_starve;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  rd_a_addr = '0;
    logic [4:0]  rd_b_addr = '0;
    logic [31:0] rf_a_data = '0;
    logic [31:0] rf_b_data = '0;
    logic [31:0] fwd_a_data;
    logic [31:0] fwd_b_data;

    wb_stage #(.DATA_W(32), .ADDR_W(5), .LL_DEPTH(DEPTH), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .ll_starve(ll_starve),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
        .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending long-latency results in arrival order.
    typedef struct {
        bit          live;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    int          blocked = 0;     // cycles the current head has been denied the port
    bit          curWe = 0;
    logic [4:0]  curRd = '0;
    logic [31:0] curData = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fwdChk(input logic [4:0] ra, input logic [31:0] rawA,
                          input logic [4:0] rb, input logic [31:0] rawB);
        logic [31:0] expA, expB;
        rd_a_addr = ra; rf_a_data = rawA;
        rd_b_addr = rb; rf_b_data = rawB;
        #1;
        expA = rawA;
        expB = rawB;
`ifdef WB_BYPASS_EN
        if (curWe && curRd == ra && ra != 0) expA = curData;
        if (curWe && curRd == rb && rb != 0) expB = curData;
`endif
        chk("fwd_a", fwd_a_data, expA);
        chk("fwd_b", fwd_b_data, expB);
    endtask

    // One clock cycle: drive inputs, predict, step the edge, compare.
    task automatic cyc(input bit pv, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
        bit          pw, rdy, acc, we, popped, wasEmpty;
        logic [4:0]  wrd;
        logic [31:0] wd;
        ent_t        e;
        pipe_valid = pv; pipe_rd = prd; pipe_data = pd;
        ll_valid = lv; ll_rd = lrd; ll_data = ld;
        #1;
        rdy = (q.size() < DEPTH);
        chk("ll_ready", 32'(ll_ready), 32'(rdy));

        pw = pv && (prd != 0);
        acc = lv && rdy;
        we = 0; wrd = '0; wd = '0; popped = 0;
        wasEmpty = (q.size() == 0);
        if (pw) begin
            we = 1; wrd = prd; wd = pd;
            foreach (q[i]) if (q[i].rd == prd) q[i].live = 0;
        end else if (!wasEmpty) begin
            e = q.pop_front();
            popped = 1;
            if (e.live) begin we = 1; wrd = e.rd; wd = e.data; end
        end
        if (wasEmpty || popped) blocked = 0;
        else if (blocked < LIM) blocked++;
        if (acc && lrd != 0 && !(pw && prd == lrd)) q.push_back('{1'b1, lrd, ld});

        @(posedge clk);
        #1;
        if (we) begin curRd = wrd; curData = wd; end
        curWe = we;
        chk("rf_we", 32'(rf_we), 32'(we));
        if (we) begin
            chk("rf_rd", 32'(rf_rd), 32'(wrd));
            chk("rf_wdata", rf_wdata, wd);
        end
        chk("ll_starve", 32'(ll_starve), 32'(blocked >= LIM));
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        pipe_valid = 0; ll_valid = 0;
        #1;
        q.delete();
        blocked = 0;
        curWe = 0;
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_ll_ready", 32'(ll_ready), 32'd0);
        chk("rst_ll_starve", 32'(ll_starve), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_rd", 32'(rf_rd), 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_ll_ready", 32'(ll_ready), 32'd1);
    endtask

    initial begin
        int pct;
        #2;
        doReset();

        // Pipe only, then rd=0 is idle.
        cyc(1, 5'd5, 32'h1234, 0, 0, 0);
        chk("pipe_rd5_data", rf_wdata, 32'h1234);
        cyc(1, 5'd0, 32'hDEAD, 0, 0, 0);
        chk("pipe_rd0_we", 32'(rf_we), 32'd0);

        // Long-latency result through an idle port.
        cyc(0, 0, 0, 1, 5'd7, 32'hAA);
        chk("ll_accept_no_bypass", 32'(rf_we), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("ll_idle_rd", 32'(rf_rd), 32'd7);
        chk("ll_idle_data", rf_wdata, 32'hAA);

        // Fill with pipe busy; third offer sees ll_ready low.
        cyc(1, 5'd4, 32'h1, 1, 5'd6, 32'hA6);
        cyc(1, 5'd5, 32'h2, 1, 5'd8, 32'hA8);
        chk("full_ready", 32'(ll_ready), 32'd0);
        cyc(1, 5'd4, 32'h3, 1, 5'd9, 32'hA9);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        // Kill: buffered rd3 overtaken by a pipeline write to rd3.
        cyc(1, 5'd10, 32'h1, 1, 5'd3, 32'h11);
        cyc(1, 5'd3, 32'h22, 0, 0, 0);
        chk("kill_new_data", rf_wdata, 32'h22);
        cyc(0, 0, 0, 0, 0, 0);
        chk("kill_dead_pop", 32'(rf_we), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Same-cycle ll and pipe to the same register: ll result dropped.
        cyc(1, 5'd12, 32'h77, 1, 5'd12, 32'h66);
        cyc(0, 0, 0, 0, 0, 0);
        chk("same_rd_drop", 32'(rf_we), 32'd0);

        // Starvation.
        cyc(1, 5'd1, 32'h100, 1, 5'd20, 32'hCC);
        for (int i = 0; i < LIM; i++) begin
            cyc(1, 5'(i + 2), 32'(i), 0, 0, 0);
            if (i == LIM - 2) chk("starve_early", 32'(ll_starve), 32'd0);
        end
        chk("starve_set", 32'(ll_starve), 32'd1);
        cyc(1, 5'd11, 32'h5, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("starve_pop_rd", 32'(rf_rd), 32'd20);
        chk("starve_clear", 32'(ll_starve), 32'd0);

        // Forwarding.
        cyc(1, 5'd9, 32'h55, 0, 0, 0);
`ifdef WB_BYPASS_EN
        fwdChk(5'd9, 32'h0, 5'd0, 32'h77);
        chk("byp_a_hit", fwd_a_data, 32'h55);
`else
        fwdChk(5'd9, 32'h0, 5'd0, 32'h77);
        chk("byp_a_off", fwd_a_data, 32'h0);
`endif
        chk("byp_b_r0", fwd_b_data, 32'h77);

        // Reset with a full FIFO: old entries never written.
        cyc(1, 5'd4, 32'h1, 1, 5'd6, 32'hB6);
        cyc(1, 5'd5, 32'h2, 1, 5'd8, 32'hB8);
        doReset();
        cyc(0, 0, 0, 0, 0, 0);
        chk("post_rst_no_wr", 32'(rf_we), 32'd0);
        cyc(0, 0, 0, 0, 0, 0);

        // Randomized traffic with varying pipeline occupancy.
        pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) pct = (n / 150) % 3 == 0 ? 30 : ((n / 150) % 3 == 1 ? 60 : 97);
            if (n == 1700) doReset();
            fwdChk($urandom_range(0, 1) ? curRd : 5'($urandom_range(0, 31)), $urandom,
                   $urandom_range(0, 3) == 0 ? 5'd0 : curRd, $urandom);
            cyc($urandom_range(0, 99) < pct, 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
